sys_tx_scheduler: RTL and testbench

Single-clock scheduler that owns the UART transmitter on the system-clock side and shares it between two requesters: the register-file read path (1 byte) and the ALU result path (16 bits, sent as 2 bytes). It arbitrates round-robin, latches the granted payload, and sequences bytes to the UART TX through a level handshake on a synchronized busy flag. It sits between the system controller's response sources and the clock-domain-crossing stage that feeds the UART TX data and valid inputs.

---
 rtl/sys_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_sys_tx_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_tx_scheduler.sv
// sys_tx_scheduler
// Shares one UART transmitter between the register-file read path (one byte)
// and the ALU result path (two bytes, LSB first). Requests are arbitrated
// round-robin. The granted payload is latched. Bytes are handed to the UART TX
// path through a level valid that stays up until the synchronized busy flag is
// seen high. An optional idle gap separates frames.

module sys_tx_scheduler #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RF_REQ,
    input  logic [7:0]  RF_DATA,
    output logic        RF_ACK,
    input  logic        ALU_REQ,
    input  logic [15:0] ALU_DATA,
    output logic        ALU_ACK,
    input  logic        TX_BUSY,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    output logic        SCHED_BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_RF  = 1'b0,
        GNT_ALU = 1'b1
    } gnt_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    state_t      state,      state_nxt;
    gnt_t        last_gnt,   last_gnt_nxt;
    logic        rf_ack_q,   rf_ack_nxt;
    logic        alu_ack_q,  alu_ack_nxt;
    logic [7:0]  tx_data_q,  tx_data_nxt;
    logic        tx_vld_q,   tx_vld_nxt;
    logic [1:0]  bytes_left, bytes_left_nxt;
    logic [7:0]  msb_byte,   msb_byte_nxt;
    logic [3:0]  gap_cnt,    gap_cnt_nxt;
    logic        pick_rf;

    // Register every piece of scheduler state; reset discards any latched frame
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_gnt   <= GNT_ALU;
            rf_ack_q   <= 1'b0;
            alu_ack_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_vld_q   <= 1'b0;
            bytes_left <= 2'd0;
            msb_byte   <= 8'h00;
            gap_cnt    <= 4'd0;
        end else begin
            state      <= state_nxt;
            last_gnt   <= last_gnt_nxt;
            rf_ack_q   <= rf_ack_nxt;
            alu_ack_q  <= alu_ack_nxt;
            tx_data_q  <= tx_data_nxt;
            tx_vld_q   <= tx_vld_nxt;
            bytes_left <= bytes_left_nxt;
            msb_byte   <= msb_byte_nxt;
            gap_cnt    <= gap_cnt_nxt;
        end
    end

    // Arbitration, byte sequencing and inter-frame gap; ACKs default low so they pulse once
    always_comb begin
        state_nxt      = state;
        last_gnt_nxt   = last_gnt;
        rf_ack_nxt     = 1'b0;
        alu_ack_nxt    = 1'b0;
        tx_data_nxt    = tx_data_q;
        tx_vld_nxt     = tx_vld_q;
        bytes_left_nxt = bytes_left;
        msb_byte_nxt   = msb_byte;
        gap_cnt_nxt    = gap_cnt;
        pick_rf        = 1'b0;

        case (state)
            IDLE: begin
                if (!TX_BUSY && (RF_REQ || ALU_REQ)) begin
                    pick_rf = RF_REQ && (!ALU_REQ || (last_gnt == GNT_ALU));
                    if (pick_rf) begin
                        last_gnt_nxt   = GNT_RF;
                        rf_ack_nxt     = 1'b1;
                        tx_data_nxt    = RF_DATA;
                        msb_byte_nxt   = 8'h00;
                        bytes_left_nxt = 2'd1;
                    end else begin
                        last_gnt_nxt   = GNT_ALU;
                        alu_ack_nxt    = 1'b1;
                        tx_data_nxt    = ALU_DATA[7:0];
                        msb_byte_nxt   = ALU_DATA[15:8];
                        bytes_left_nxt = 2'd2;
                    end
                    tx_vld_nxt = 1'b1;
                    state_nxt  = SEND;
                end
            end

            SEND: begin
                if (TX_BUSY) begin
                    tx_vld_nxt     = 1'b0;
                    bytes_left_nxt = bytes_left - 2'd1;
                    state_nxt      = DRAIN;
                end
            end

            DRAIN: begin
                if (!TX_BUSY) begin
                    if (bytes_left != 2'd0) begin
                        tx_data_nxt = msb_byte;
                        tx_vld_nxt  = 1'b1;
                        state_nxt   = SEND;
                    end else if (GAP_LOAD == 4'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_cnt_nxt = GAP_LOAD;
                        state_nxt   = GAP;
                    end
                end
            end

            GAP: begin
                if (gap_cnt <= 4'd1) begin
                    gap_cnt_nxt = 4'd0;
                    state_nxt   = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign RF_ACK     = rf_ack_q;
    assign ALU_ACK    = alu_ack_q;
    assign TX_P_DATA  = tx_data_q;
    assign TX_D_VLD   = tx_vld_q;
    assign SCHED_BUSY = (state != IDLE);

endmodule

// File: tb/tb_sys_tx_scheduler.sv
// tb_sys_tx_scheduler
// Two scheduler instances (GAP_CYCLES=2 and GAP_CYCLES=0) with their own inputs.
// A frame-level reference model (byte queue plus cycle-number gap bookkeeping)
// predicts the outputs after every clock edge. Directed sequences add literal checks.

module tb_sys_tx_scheduler;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    logic        rf_req    [2];
    logic [7:0]  rf_data   [2];
    logic        alu_req   [2];
    logic [15:0] alu_data  [2];
    logic        tx_busy   [2];
    logic        rf_ack    [2];
    logic        alu_ack   [2];
    logic [7:0]  tx_p_data [2];
    logic        tx_d_vld  [2];
    logic        sched_busy[2];

    int checks = 0;
    int errors = 0;

    sys_tx_scheduler #(.GAP_CYCLES(2)) dut_gap2 (
        .CLK(CLK), .RST(RST),
        .RF_REQ(rf_req[0]), .RF_DATA(rf_data[0]), .RF_ACK(rf_ack[0]),
        .ALU_REQ(alu_req[0]), .ALU_DATA(alu_data[0]), .ALU_ACK(alu_ack[0]),
        .TX_BUSY(tx_busy[0]), .TX_P_DATA(tx_p_data[0]), .TX_D_VLD(tx_d_vld[0]),
        .SCHED_BUSY(sched_busy[0])
    );

    sys_tx_scheduler #(.GAP_CYCLES(0)) dut_gap0 (
        .CLK(CLK), .RST(RST),
        .RF_REQ(rf_req[1]), .RF_DATA(rf_data[1]), .RF_ACK(rf_ack[1]),
        .ALU_REQ(alu_req[1]), .ALU_DATA(alu_data[1]), .ALU_ACK(alu_ack[1]),
        .TX_BUSY(tx_busy[1]), .TX_P_DATA(tx_p_data[1]), .TX_D_VLD(tx_d_vld[1]),
        .SCHED_BUSY(sched_busy[1])
    );

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          m_last_alu [2] = '{1'b1, 1'b1};
    logic [7:0]  m_q        [2][$];
    bit          m_in_frame [2] = '{1'b0, 1'b0};
    bit          m_present  [2] = '{1'b0, 1'b0};
    int          m_ready    [2] = '{0, 0};
    logic        e_rf_ack   [2] = '{1'b0, 1'b0};
    logic        e_alu_ack  [2] = '{1'b0, 1'b0};
    logic        e_vld      [2] = '{1'b0, 1'b0};
    logic [7:0]  e_data     [2] = '{8'h00, 8'h00};

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic model_reset(input int k);
        m_last_alu[k] = 1'b1;
        m_q[k].delete();
        m_in_frame[k] = 1'b0;
        m_present[k]  = 1'b0;
        m_ready[k]    = 0;
        e_rf_ack[k]   = 1'b0;
        e_alu_ack[k]  = 1'b0;
        e_vld[k]      = 1'b0;
        e_data[k]     = 8'h00;
    endtask

    task automatic model_step(input int k);
        logic [7:0] dropped;
        e_rf_ack[k]  = 1'b0;
        e_alu_ack[k] = 1'b0;
        if (!m_in_frame[k]) begin
            if (cyc >= m_ready[k] && !tx_busy[k] && (rf_req[k] || alu_req[k])) begin
                if (rf_req[k] && (!alu_req[k] || m_last_alu[k])) begin
                    m_last_alu[k] = 1'b0;
                    e_rf_ack[k]   = 1'b1;
                    m_q[k].push_back(rf_data[k]);
                end else begin
                    m_last_alu[k] = 1'b1;
                    e_alu_ack[k]  = 1'b1;
                    m_q[k].push_back(alu_data[k][7:0]);
                    m_q[k].push_back(alu_data[k][15:8]);
                end
                e_data[k]     = m_q[k][0];
                e_vld[k]      = 1'b1;
                m_present[k]  = 1'b1;
                m_in_frame[k] = 1'b1;
            end
        end else if (m_present[k]) begin
            if (tx_busy[k]) begin
                m_present[k] = 1'b0;
                e_vld[k]     = 1'b0;
                dropped      = m_q[k].pop_front();
            end
        end else if (!tx_busy[k]) begin
            if (m_q[k].size() > 0) begin
                e_data[k]    = m_q[k][0];
                e_vld[k]     = 1'b1;
                m_present[k] = 1'b1;
            end else begin
                m_in_frame[k] = 1'b0;
                m_ready[k]    = cyc + gap_of(k) + 1;
            end
        end
    endtask

    // Advance the model on every edge, mirroring the asynchronous reset
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 2; k++) model_reset(k);
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the model every cycle, mid-period
    always @(negedge CLK) begin
        if (!RST) begin
            for (int k = 0; k < 2; k++) begin
                check_output($sformatf("u%0d_rf_ack", k),  16'(rf_ack[k]),     16'(e_rf_ack[k]));
                check_output($sformatf("u%0d_alu_ack", k), 16'(alu_ack[k]),    16'(e_alu_ack[k]));
                check_output($sformatf("u%0d_vld", k),     16'(tx_d_vld[k]),   16'(e_vld[k]));
                check_output($sformatf("u%0d_data", k),    16'(tx_p_data[k]),  16'(e_data[k]));
                check_output($sformatf("u%0d_busy", k),    16'(sched_busy[k]),
                             16'(m_in_frame[k] || (cyc + 1 < m_ready[k])));
            end
        end
    end

    // Grant log and ACK counters for instance 0 (sampled before the edge updates ACK)
    int rf_cnt  = 0;
    int alu_cnt = 0;
    int glog[$];
    always @(posedge CLK) begin
        if (!RST) begin
            if (rf_ack[0])  begin rf_cnt++;  glog.push_back(0); end
            if (alu_ack[0]) begin alu_cnt++; glog.push_back(1); end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic apply_stimulus(input int k, input logic rq, input logic [7:0] rd,
                                  input logic aq, input logic [15:0] ad);
        rf_req[k]   = rq;
        rf_data[k]  = rd;
        alu_req[k]  = aq;
        alu_data[k] = ad;
    endtask

    task automatic wait_vld(input int k);
        int n = 0;
        while (!tx_d_vld[k] && n < 100) begin tick(); n++; end
        check_output("vld_wait", 16'(tx_d_vld[k]), 16'd1);
    endtask

    task automatic wait_ack(input int k, input bit alu);
        int n = 0;
        while (!(alu ? alu_ack[k] : rf_ack[k]) && n < 100) begin tick(); n++; end
        check_output("ack_wait", 16'(alu ? alu_ack[k] : rf_ack[k]), 16'd1);
    endtask

    // One UART byte: accept after 'hold' cycles, stay busy for 3 cycles
    task automatic uart_byte(input int k, input logic [7:0] exp, input int hold);
        wait_vld(k);
        check_output("byte", 16'(tx_p_data[k]), 16'(exp));
        for (int i = 0; i < hold; i++) begin
            tick();
            check_output("hold_vld",  16'(tx_d_vld[k]),  16'd1);
            check_output("hold_data", 16'(tx_p_data[k]), 16'(exp));
        end
        tx_busy[k] = 1'b1;
        tick();
        check_output("vld_drop", 16'(tx_d_vld[k]), 16'd0);
        repeat (2) tick();
        tx_busy[k] = 1'b0;
        tick();
    endtask

    initial begin
        int rf0, alu0, gstart;
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(k, 1'b0, 8'h00, 1'b0, 16'h0000);
            tx_busy[k] = 1'b0;
        end
        RST = 1'b1;
        #1;
        check_output("rst_rf_ack",  16'(rf_ack[0]),     16'd0);
        check_output("rst_alu_ack", 16'(alu_ack[0]),    16'd0);
        check_output("rst_data",    16'(tx_p_data[0]),  16'h00);
        check_output("rst_vld",     16'(tx_d_vld[0]),   16'd0);
        check_output("rst_busy",    16'(sched_busy[0]), 16'd0);
        repeat (2) tick();
        RST = 1'b0;
        repeat (2) tick();

        // Single RF byte, GAP_CYCLES=2
        rf0 = rf_cnt;
        apply_stimulus(0, 1'b1, 8'hA5, 1'b0, 16'h0000);
        tick();
        check_output("t1_ack",  16'(rf_ack[0]),     16'd1);
        check_output("t1_vld",  16'(tx_d_vld[0]),   16'd1);
        check_output("t1_data", 16'(tx_p_data[0]),  16'hA5);
        check_output("t1_busy", 16'(sched_busy[0]), 16'd1);
        tick();
        check_output("t1_ack_once", 16'(rf_ack[0]), 16'd0);
        apply_stimulus(0, 1'b0, 8'hA5, 1'b0, 16'h0000);
        repeat (2) tick();
        check_output("t1_vld_held", 16'(tx_d_vld[0]), 16'd1);
        tx_busy[0] = 1'b1;
        tick();
        check_output("t1_vld_fall", 16'(tx_d_vld[0]), 16'd0);
        repeat (2) tick();
        tx_busy[0] = 1'b0;
        tick();
        check_output("t1_gap_a", 16'(sched_busy[0]), 16'd1);
        tick();
        check_output("t1_gap_b", 16'(sched_busy[0]), 16'd1);
        tick();
        check_output("t1_idle",  16'(sched_busy[0]), 16'd0);
        check_output("t1_nack",  16'(rf_cnt - rf0), 16'd1);

        // ALU 16'h1234: LSB then MSB, one ACK
        alu0 = alu_cnt;
        apply_stimulus(0, 1'b0, 8'h00, 1'b1, 16'h1234);
        wait_ack(0, 1'b1);
        tick();
        apply_stimulus(0, 1'b0, 8'h00, 1'b0, 16'h1234);
        uart_byte(0, 8'h34, 0);
        uart_byte(0, 8'h12, 0);
        repeat (4) tick();
        check_output("t2_nack", 16'(alu_cnt - alu0), 16'd1);

        // Simultaneous continuous requests alternate RF, ALU, RF, ALU
        gstart = glog.size();
        apply_stimulus(0, 1'b1, 8'h5A, 1'b1, 16'hBEEF);
        tick();
        check_output("t3_first_rf", 16'(rf_ack[0]), 16'd1);
        uart_byte(0, 8'h5A, 0);
        uart_byte(0, 8'hEF, 0);
        uart_byte(0, 8'hBE, 0);
        uart_byte(0, 8'h5A, 0);
        uart_byte(0, 8'hEF, 0);
        apply_stimulus(0, 1'b0, 8'h5A, 1'b0, 16'hBEEF);
        uart_byte(0, 8'hBE, 0);
        repeat (6) tick();
        check_output("t3_ngrants", 16'(glog.size() - gstart), 16'd4);
        for (int i = 0; i < 4 && gstart + i < glog.size(); i++)
            check_output($sformatf("t3_order%0d", i), 16'(glog[gstart + i]), 16'(i % 2));

        // TX_BUSY delayed 50 cycles: byte held, no further grants
        rf0 = rf_cnt; alu0 = alu_cnt;
        apply_stimulus(0, 1'b1, 8'h3C, 1'b0, 16'h0000);
        wait_ack(0, 1'b0);
        tick();
        apply_stimulus(0, 1'b0, 8'h3C, 1'b0, 16'h0000);
        uart_byte(0, 8'h3C, 50);
        repeat (4) tick();
        check_output("t4_rf_once", 16'(rf_cnt - rf0), 16'd1);
        check_output("t4_no_alu",  16'(alu_cnt - alu0), 16'd0);

        // Reset during the MSB byte of an ALU frame while UART stays busy
        apply_stimulus(0, 1'b0, 8'h00, 1'b1, 16'hCAFE);
        wait_ack(0, 1'b1);
        tick();
        apply_stimulus(0, 1'b0, 8'h00, 1'b0, 16'hCAFE);
        uart_byte(0, 8'hFE, 0);
        check_output("t5_msb", 16'(tx_p_data[0]), 16'hCA);
        apply_stimulus(0, 1'b1, 8'h77, 1'b0, 16'h0000);
        #2;
        RST = 1'b1;
        tx_busy[0] = 1'b1;
        #1;
        check_output("t5_rst_vld",  16'(tx_d_vld[0]),   16'd0);
        check_output("t5_rst_data", 16'(tx_p_data[0]),  16'h00);
        check_output("t5_rst_busy", 16'(sched_busy[0]), 16'd0);
        check_output("t5_rst_ack",  16'(alu_ack[0]),    16'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("t5_blocked", 16'(rf_ack[0]), 16'd0);
        end
        tx_busy[0] = 1'b0;
        tick();
        check_output("t5_grant",      16'(rf_ack[0]),    16'd1);
        check_output("t5_grant_data", 16'(tx_p_data[0]), 16'h77);
        tick();
        apply_stimulus(0, 1'b0, 8'h77, 1'b0, 16'h0000);
        uart_byte(0, 8'h77, 0);
        repeat (4) tick();

        // GAP_CYCLES=0: back-to-back RF grants
        apply_stimulus(1, 1'b1, 8'h11, 1'b0, 16'h0000);
        wait_ack(1, 1'b0);
        tick();
        apply_stimulus(1, 1'b0, 8'h11, 1'b0, 16'h0000);
        tick();
        apply_stimulus(1, 1'b1, 8'h22, 1'b0, 16'h0000);
        check_output("t6_first", 16'(tx_p_data[1]), 16'h11);
        tx_busy[1] = 1'b1;
        tick();
        check_output("t6_vld_fall", 16'(tx_d_vld[1]), 16'd0);
        tick();
        tx_busy[1] = 1'b0;
        tick();
        check_output("t6_idle",   16'(sched_busy[1]), 16'd0);
        check_output("t6_no_ack", 16'(rf_ack[1]),     16'd0);
        tick();
        check_output("t6_grant",  16'(rf_ack[1]),     16'd1);
        check_output("t6_data",   16'(tx_p_data[1]),  16'h22);
        tick();
        apply_stimulus(1, 1'b0, 8'h22, 1'b0, 16'h0000);
        uart_byte(1, 8'h22, 0);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
